dmem_responder: RTL and testbench

- Data-memory responder for the 16-bit gigaHurt CPU.
- Serves the load/store requests the datapath issues: `aluout` is the address and `writedata` is the store data. Load results are returned as `readdata`.
- Sits between the datapath/controller and on-chip storage.
- Uses a valid/ready request channel and a valid/ready response channel, with a parameterised number of wait states, so the datapath can be tested against a non-zero-latency memory.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between the gigaHurt
// datapath (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int n = 16
);
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [n-1:0] req_addr;
  logic [n-1:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [n-1:0] resp_rdata;
  logic         resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the 16-bit gigaHurt CPU.
// Accepts one load/store at a time, waits LATENCY cycles, then presents a
// response held until consumed. Storage is 2**AW halfwords, not cleared by reset.
// Optional macro DMEM_MISALIGN_CHECK_EN: odd addresses are rejected with
// resp_err=1, rdata=0 and no write; otherwise bit 0 is ignored.
module dmem_responder #(
  parameter int n       = 16,
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  dmem_responder_if.slave     bus,
  output logic                busy
);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "dmem_responder: LATENCY must be within 0..15");
  end

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic         h_we;
  logic [n-1:0] h_addr;
  logic [n-1:0] h_wdata;
  logic [n-1:0] rdata_q;
  logic         err_q;

  logic [n-1:0] mem [2**AW] = '{default: '0};

  logic          a_we;
  logic [n-1:0]  a_addr;
  logic [n-1:0]  a_wdata;
  logic [AW-1:0] idx;
  logic          mis;
  logic          commit;

  // With LATENCY=0 the access commits on the acceptance edge, so the live
  // request lines feed the access directly; otherwise the holding registers do.
  always_comb begin
    a_we    = (state == IDLE) ? bus.req_we    : h_we;
    a_addr  = (state == IDLE) ? bus.req_addr  : h_addr;
    a_wdata = (state == IDLE) ? bus.req_wdata : h_wdata;
    idx     = a_addr[AW:1];
`ifdef DMEM_MISALIGN_CHECK_EN
    mis     = a_addr[0];
`else
    mis     = 1'b0;
`endif
    commit  = ((state == IDLE) && bus.req_valid && (LATENCY == 0)) ||
              ((state == WAIT) && (cnt == '0));
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    busy           = 1'b1;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
        if (bus.req_valid) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, wait counter, request capture and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      h_we    <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && bus.req_valid) begin
        h_we    <= bus.req_we;
        h_addr  <= bus.req_addr;
        h_wdata <= bus.req_wdata;
        cnt     <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rdata_q <= (a_we || mis) ? '0 : mem[idx];
        err_q   <= mis;
      end
    end
  end

  // Storage write port; no reset so an aborted store never reaches here.
  always_ff @(posedge clk) begin
    if (commit && a_we && !mis) mem[idx] <= a_wdata;
  end

  assign bus.resp_rdata = rdata_q;

  logic unused_bits;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign bus.resp_err = err_q;
  assign unused_bits  = ^a_addr[n-1:AW+1];
`else
  assign bus.resp_err = 1'b0;
  assign unused_bits  = ^{a_addr[n-1:AW+1], a_addr[0], err_q};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with LATENCY=2 and
// LATENCY=0 instances sharing clock and reset.
module tb_dmem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy2, busy0;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if #(.n(16)) b2 ();
  dmem_responder_if #(.n(16)) b0 ();

  dmem_responder #(.n(16), .AW(8), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(b2), .busy(busy2)
  );
  dmem_responder #(.n(16), .AW(8), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(b0), .busy(busy0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance; optional response stall with
  // a spurious store pulse that must be ignored.
  task automatic xact2(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rd, input logic exp_err, input int stall);
    int edges;
    @(negedge clk);
    b2.req_valid  = 1'b1;
    b2.req_we     = we;
    b2.req_addr   = addr;
    b2.req_wdata  = wdata;
    b2.resp_ready = (stall == 0);
    check("rdy_idle", b2.req_ready, 1);
    @(posedge clk); #1;
    b2.req_valid = 1'b0;
    edges = 0;
    while (!b2.resp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", edges, 2);
    check("rdata", b2.resp_rdata, exp_rd);
    check("err", b2.resp_err, exp_err);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", b2.resp_valid, 1);
      check("stall_rdata", b2.resp_rdata, exp_rd);
      check("stall_rdy", b2.req_ready, 0);
      b2.req_valid = (i == 1);
      b2.req_we    = 1'b1;
      b2.req_addr  = 16'h0030;
      b2.req_wdata = 16'h7777;
    end
    @(negedge clk);
    b2.req_valid  = 1'b0;
    b2.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("done_valid", b2.resp_valid, 0);
    check("done_rdy", b2.req_ready, 1);
    check("done_busy", busy2, 0);
  endtask

  initial begin
    int edges;
    b2.req_valid = 0; b2.req_we = 0; b2.req_addr = '0; b2.req_wdata = '0; b2.resp_ready = 1;
    b0.req_valid = 0; b0.req_we = 0; b0.req_addr = '0; b0.req_wdata = '0; b0.resp_ready = 1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rdy", b2.req_ready, 1);
    check("rst_valid", b2.resp_valid, 0);
    check("rst_rdata", b2.resp_rdata, 0);
    check("rst_err", b2.resp_err, 0);
    check("rst_busy", busy2, 0);
    check("rst_rdy0", b0.req_ready, 1);
    reset = 1'b1;

    // Basic store/load
    xact2(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 0);
    xact2(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0);

    // Backpressure with ignored spurious store to 0x0030
    xact2(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 5);
    xact2(1'b0, 16'h0030, 16'h0000, 16'h0000, 1'b0, 0);

    // Address wrap
    xact2(1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0, 0);
    xact2(1'b1, 16'h0202, 16'h00AA, 16'h0000, 1'b0, 0);
    xact2(1'b0, 16'h0002, 16'h0000, 16'h00AA, 1'b0, 0);
    xact2(1'b0, 16'h0200, 16'h0000, 16'h1111, 1'b0, 0);

    // Reset during WAIT aborts a store
    @(negedge clk);
    b2.req_valid = 1; b2.req_we = 1; b2.req_addr = 16'h0020; b2.req_wdata = 16'h5555;
    @(posedge clk); #1;
    b2.req_valid = 0;
    check("wait_busy", busy2, 1);
    reset = 1'b0;
    #1;
    check("abort_rdy", b2.req_ready, 1);
    check("abort_valid", b2.resp_valid, 0);
    check("abort_rdata", b2.resp_rdata, 0);
    check("abort_busy", busy2, 0);
    @(negedge clk);
    reset = 1'b1;
    xact2(1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 0);

    // Reset during RESP keeps a committed store
    @(negedge clk);
    b2.req_valid = 1; b2.req_we = 1; b2.req_addr = 16'h0040; b2.req_wdata = 16'h4242;
    b2.resp_ready = 0;
    @(posedge clk); #1;
    b2.req_valid = 0;
    edges = 0;
    while (!b2.resp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("resp_seen", b2.resp_valid, 1);
    reset = 1'b0;
    #1;
    check("drop_valid", b2.resp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    b2.resp_ready = 1;
    xact2(1'b0, 16'h0040, 16'h0000, 16'h4242, 1'b0, 0);

    // Misaligned access
`ifdef DMEM_MISALIGN_CHECK_EN
    xact2(1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 0);
    xact2(1'b1, 16'h0011, 16'h9999, 16'h0000, 1'b1, 0);
    xact2(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 0);
`else
    xact2(1'b0, 16'h0011, 16'h0000, 16'hBEEF, 1'b0, 0);
`endif

    // LATENCY=0: store then load back-to-back with req_valid held high
    @(negedge clk);
    b0.req_valid = 1; b0.req_we = 1; b0.req_addr = 16'h0004; b0.req_wdata = 16'h1234;
    @(negedge clk);
    check("l0_st_valid", b0.resp_valid, 1);
    check("l0_st_rdata", b0.resp_rdata, 0);
    check("l0_st_rdy", b0.req_ready, 0);
    b0.req_we = 0; b0.req_wdata = 16'h0000;
    @(negedge clk);
    check("l0_idle_rdy", b0.req_ready, 1);
    check("l0_idle_valid", b0.resp_valid, 0);
    @(negedge clk);
    check("l0_ld_valid", b0.resp_valid, 1);
    check("l0_ld_rdata", b0.resp_rdata, 16'h1234);
    check("l0_ld_err", b0.resp_err, 0);
    b0.req_valid = 0;
    @(negedge clk);
    check("l0_end_valid", b0.resp_valid, 0);
    check("l0_end_busy", busy0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
